// File: rtl/trig_accept.sv
// trig_accept: turns stretched fire edges into accepted triggers with prescale,
// a fixed gate and dead time, the DAQ busy veto, and saturating accept/veto counters.
module trig_accept #(
  parameter int NCH        = 48,
  parameter int TRIG_WIDTH = 6,
  parameter int GATE_WIDTH = 20,
  parameter int DEAD_TIME  = 40,
  parameter int PS_W       = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire_in,
  input  logic [NCH-1:0]   hit_pattern,
  input  logic [PS_W-1:0]  prescale,
  input  logic             daq_busy,
  input  logic             clear_counters,
  output logic             trig_out,
  output logic             gate_out,
  output logic [NCH-1:0]   pattern_out,
  output logic             pattern_valid,
  output logic             live,
  output logic [CNT_W-1:0] accepted_count,
  output logic [CNT_W-1:0] vetoed_count
);

  typedef enum logic [1:0] {IDLE, GATE, DEAD, BUSYWAIT} state_t;

  localparam int TMAX  = (GATE_WIDTH > DEAD_TIME) ? GATE_WIDTH : DEAD_TIME;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_WIDTH - 1);
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_WIDTH - 1);
  localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [PS_W-1:0]  ps_cnt;
  logic             fire_d;
  logic             armed;
  logic             fire_edge;
  logic             eligible;
  logic             accept;
  logic             veto;
  logic             trig_nxt;
  logic             gate_nxt;

  // armed stays low for the first cycle after reset so a level that is
  // still high when reset releases is not mistaken for a fresh edge.
  always_comb begin
    fire_edge = fire_in & ~fire_d & armed;
    eligible  = fire_edge && (state == IDLE) && !daq_busy;
    accept    = eligible && (ps_cnt >= prescale);
    veto      = fire_edge && ((state != IDLE) || daq_busy);
    trig_nxt  = accept || ((state == GATE) && (timer < TRIG_LAST));
    gate_nxt  = accept || ((state == GATE) && (timer != GATE_LAST));
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = GATE;
          timer_nxt = '0;
        end
      end
      GATE: begin
        if (timer == GATE_LAST) begin
          timer_nxt = '0;
          if (DEAD_TIME > 0) state_nxt = DEAD;
          else               state_nxt = daq_busy ? BUSYWAIT : IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      DEAD: begin
        if (timer == DEAD_LAST) begin
          timer_nxt = '0;
          state_nxt = daq_busy ? BUSYWAIT : IDLE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      BUSYWAIT: begin
        if (!daq_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      fire_d        <= 1'b0;
      armed         <= 1'b0;
      ps_cnt        <= '0;
      trig_out      <= 1'b0;
      gate_out      <= 1'b0;
      pattern_out   <= '0;
      pattern_valid <= 1'b0;
      live          <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      fire_d        <= fire_in;
      armed         <= 1'b1;
      trig_out      <= trig_nxt;
      gate_out      <= gate_nxt;
      pattern_valid <= accept;
      live          <= (state == IDLE) && !daq_busy;
      if (accept) pattern_out <= hit_pattern;
      if (eligible) ps_cnt <= accept ? '0 : ps_cnt + PS_W'(1);
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear_counters) begin
      accepted_count <= '0;
      vetoed_count   <= '0;
    end else begin
      if (accept && (accepted_count != CNT_MAX)) accepted_count <= accepted_count + CNT_W'(1);
      if (veto && (vetoed_count != CNT_MAX))     vetoed_count   <= vetoed_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trig_accept.sv
// Bench for trig_accept: timestamp-based reference model checked every cycle,
// a table of edge vectors, random stimulus and hand-written corner sequences.
module tb_trig_accept;
  localparam int NCH   = 48;
  localparam int TW    = 6;
  localparam int GW    = 20;
  localparam int DT    = 40;
  localparam int PS_W  = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fire_in = 1'b0;
  logic             daq_busy = 1'b0;
  logic             clear_counters = 1'b0;
  logic [NCH-1:0]   hit_pattern = '0;
  logic [PS_W-1:0]  prescale = '0;

  logic             trig_out, gate_out, pattern_valid, live;
  logic [NCH-1:0]   pattern_out;
  logic [CNT_W-1:0] accepted_count, vetoed_count;

  logic             s_trig, s_gate, s_valid, s_live;
  logic [NCH-1:0]   s_pattern;
  logic [3:0]       s_acc, s_veto;

  int n_checks = 0;
  int n_fail   = 0;

  trig_accept #(.NCH(NCH), .TRIG_WIDTH(TW), .GATE_WIDTH(GW), .DEAD_TIME(DT),
                .PS_W(PS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fire_in(fire_in), .hit_pattern(hit_pattern),
    .prescale(prescale), .daq_busy(daq_busy), .clear_counters(clear_counters),
    .trig_out(trig_out), .gate_out(gate_out), .pattern_out(pattern_out),
    .pattern_valid(pattern_valid), .live(live),
    .accepted_count(accepted_count), .vetoed_count(vetoed_count));

  // Narrow-counter variant with no dead time, used for saturation.
  trig_accept #(.NCH(NCH), .TRIG_WIDTH(1), .GATE_WIDTH(2), .DEAD_TIME(0),
                .PS_W(PS_W), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .fire_in(fire_in), .hit_pattern(hit_pattern),
    .prescale(prescale), .daq_busy(daq_busy), .clear_counters(clear_counters),
    .trig_out(s_trig), .gate_out(s_gate), .pattern_out(s_pattern),
    .pattern_valid(s_valid), .live(s_live),
    .accepted_count(s_acc), .vetoed_count(s_veto));

  always #5 clk = ~clk;

  int m_t = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, m_t, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NCH-1:0] randPat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NCH-1:0];
  endfunction

  // Reference model: tracks the last accept time and when the block is free
  // again, and derives every expected output from those timestamps.
  bit             chk_en = 0;
  longint         m_acc = 0, m_veto = 0;
  int             last_acc = -1000;
  int             free_from = 0;
  int             decide_at = -1;
  int             m_ps = 0;
  logic [NCH-1:0] m_pat = '0;
  bit             bw = 0, m_fire_d = 0, m_mask = 1, m_live = 0;

  always @(negedge clk) begin
    bit m_edge, idle;
    int d;
    d = m_t - last_acc;
    if (chk_en) begin
      checkOutput("model_trig", 64'(trig_out), 64'(d >= 1 && d <= TW));
      checkOutput("model_gate", 64'(gate_out), 64'(d >= 1 && d <= GW));
      checkOutput("model_valid", 64'(pattern_valid), 64'(d == 1));
      checkOutput("model_pattern", 64'(pattern_out), 64'(m_pat));
      checkOutput("model_live", 64'(live), 64'(m_live));
      checkOutput("model_accepted", 64'(accepted_count), 64'(m_acc));
      checkOutput("model_vetoed", 64'(vetoed_count), 64'(m_veto));
    end
    if (reset) begin
      m_acc = 0; m_veto = 0; last_acc = -1000; m_pat = '0; m_ps = 0;
      free_from = m_t + 1; decide_at = -1; bw = 0;
      m_fire_d = 0; m_mask = 1; m_live = 0;
    end else begin
      m_edge   = fire_in && !m_fire_d && !m_mask;
      m_mask   = 0;
      m_fire_d = fire_in;
      idle     = (m_t >= free_from) && !bw;
      m_live   = idle && !daq_busy;
      if (m_edge) begin
        if (!idle || daq_busy) m_veto++;
        else if (m_ps >= int'(prescale)) begin
          last_acc  = m_t;
          m_pat     = hit_pattern;
          m_acc++;
          m_ps      = 0;
          decide_at = m_t + GW + DT;
          free_from = decide_at + 1;
        end else m_ps++;
      end
      if (m_t == decide_at) bw = daq_busy;
      else if (bw && !daq_busy) begin
        bw = 0;
        free_from = m_t + 1;
      end
      if (clear_counters) begin
        m_acc = 0;
        m_veto = 0;
      end
    end
    m_t++;
  end

  typedef struct {
    int              gap;
    int              width;
    logic [PS_W-1:0] ps;
    logic            busy;
    logic            exp_acc;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input int gap, input int width, input int ps, input bit busy, input bit exp_acc);
    vec_t v;
    v.gap = gap; v.width = width; v.ps = PS_W'(ps); v.busy = busy; v.exp_acc = exp_acc;
    vq.push_back(v);
  endtask

  // Low for gap cycles, then a width-cycle pulse; checks the accept decision at n+1.
  task automatic applyStimulus(input vec_t v);
    logic [NCH-1:0] pat;
    prescale = v.ps;
    daq_busy = v.busy;
    fire_in  = 1'b0;
    tick(v.gap);
    pat = randPat();
    fire_in = 1'b1;
    hit_pattern = pat;
    tick(1);
    fire_in = (v.width > 1);
    @(negedge clk);
    checkOutput("vec_trig", 64'(trig_out), 64'(v.exp_acc));
    checkOutput("vec_valid", 64'(pattern_valid), 64'(v.exp_acc));
    if (v.exp_acc) checkOutput("vec_pattern", 64'(pattern_out), 64'(pat));
    @(posedge clk);
    #1;
    if (v.width > 2) tick(v.width - 2);
    fire_in  = 1'b0;
    daq_busy = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    fire_in = 1'b0;
    daq_busy = 1'b0;
    clear_counters = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NCH-1:0] pat;
    tick(1);
    chk_en = 1;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Single pulse, exact trig/gate/valid windows relative to the edge.
    prescale = '0;
    for (int k = 0; k < 45; k++) begin
      fire_in = (k < 6);
      hit_pattern = (k < 6) ? NCH'(1) : '0;
      @(negedge clk);
      checkOutput("t1_trig", 64'(trig_out), 64'(k >= 1 && k <= 6));
      checkOutput("t1_gate", 64'(gate_out), 64'(k >= 1 && k <= 20));
      checkOutput("t1_valid", 64'(pattern_valid), 64'(k == 1));
      if (k == 1) checkOutput("t1_pattern", 64'(pattern_out), 64'h1);
      @(posedge clk);
      #1;
    end
    checkOutput("t1_accepted", 64'(accepted_count), 64'd1);
    checkOutput("t1_vetoed", 64'(vetoed_count), 64'd0);
    tick(20);

    // Edge spacing, prescale 1-of-4, busy veto and prescale shrink.
    addVec(5, 6, 0, 0, 1);
    addVec(19, 6, 0, 0, 0);
    addVec(30, 6, 0, 0, 1);
    addVec(54, 1, 0, 0, 0);
    addVec(1, 6, 0, 0, 1);
    for (int i = 0; i < 12; i++) addVec(70, 6, 3, 0, (i % 4) == 3);
    addVec(70, 6, 0, 1, 0);
    addVec(70, 6, 0, 0, 1);
    for (int i = 0; i < 3; i++) addVec(70, 6, 5, 0, 0);
    addVec(70, 6, 1, 0, 1);
    addVec(70, 6, 0, 0, 1);
    foreach (vq[i]) applyStimulus(vq[i]);
    tick(70);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) fire_in = ~fire_in;
      if ($urandom_range(0, 39) == 0) daq_busy = ~daq_busy;
      if ($urandom_range(0, 199) == 0) prescale = PS_W'($urandom_range(0, 3));
      hit_pattern = randPat();
      clear_counters = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    reset = 1'b0;
    clear_counters = 1'b0;
    prescale = '0;

    // Long busy window: accept, veto, live low through BUSYWAIT, then accept.
    doReset();
    for (int k = 0; k < 220; k++) begin
      fire_in = (k >= 10 && k < 16) || (k >= 100 && k < 106) || (k >= 210 && k < 216);
      daq_busy = (k >= 30 && k <= 200);
      @(negedge clk);
      if (k == 11) checkOutput("busy_first_accept", 64'(accepted_count), 64'd1);
      if (k == 101) checkOutput("busy_veto", 64'(vetoed_count), 64'd1);
      if (k == 101) checkOutput("busy_no_trig", 64'(trig_out), 64'd0);
      if (k >= 31 && k <= 201) checkOutput("busy_live_low", 64'(live), 64'd0);
      if (k == 205) checkOutput("busy_live_back", 64'(live), 64'd1);
      if (k == 211) checkOutput("busy_reaccept", 64'(accepted_count), 64'd2);
      @(posedge clk);
      #1;
    end
    fire_in = 1'b0;
    daq_busy = 1'b0;
    tick(70);

    // Saturation of the 4-bit counters, then clear coincident with an accept.
    doReset();
    for (int e = 0; e < 20; e++) begin
      pat = randPat();
      fire_in = 1'b1;
      hit_pattern = pat;
      tick(1);
      @(negedge clk);
      checkOutput("small_trig_on", 64'(s_trig), 64'd1);
      checkOutput("small_gate_on", 64'(s_gate), 64'd1);
      checkOutput("small_valid", 64'(s_valid), 64'd1);
      checkOutput("small_pattern", 64'(s_pattern), 64'(pat));
      @(posedge clk);
      #1;
      fire_in = 1'b0;
      @(negedge clk);
      checkOutput("small_trig_off", 64'(s_trig), 64'd0);
      checkOutput("small_gate_hold", 64'(s_gate), 64'd1);
      checkOutput("small_live_low", 64'(s_live), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("small_gate_off", 64'(s_gate), 64'd0);
      @(posedge clk);
      #1;
      tick(66);
    end
    checkOutput("small_acc_sat", 64'(s_acc), 64'd15);
    checkOutput("small_veto", 64'(s_veto), 64'd0);
    checkOutput("small_live_idle", 64'(s_live), 64'd1);
    checkOutput("big_acc_20", 64'(accepted_count), 64'd20);
    fire_in = 1'b1;
    clear_counters = 1'b1;
    tick(1);
    clear_counters = 1'b0;
    @(negedge clk);
    checkOutput("clear_acc", 64'(accepted_count), 64'd0);
    checkOutput("clear_small_acc", 64'(s_acc), 64'd0);
    checkOutput("clear_still_trig", 64'(trig_out), 64'd1);
    @(posedge clk);
    #1;
    fire_in = 1'b0;
    tick(70);

    // Reset in the middle of a gate while fire_in stays high.
    for (int k = 0; k < 50; k++) begin
      reset = (k == 15);
      fire_in = (k < 30) || (k >= 35);
      @(negedge clk);
      if (k == 1) checkOutput("rst_trig_start", 64'(trig_out), 64'd1);
      if (k == 16) checkOutput("rst_gate_drop", 64'(gate_out), 64'd0);
      if (k >= 16 && k <= 35) checkOutput("rst_no_trig", 64'(trig_out), 64'd0);
      if (k == 36) checkOutput("rst_new_accept", 64'(trig_out), 64'd1);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    fire_in = 1'b0;
    tick(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_accept.md
Name: trig_accept

Overview:
- Downstream of the scatter-trigger OR stage.
- Consumes the stretched `fire` level and the stretched 48-bit hit pattern.
- Decides whether each new fire edge becomes an accepted trigger, using prescale, a fixed dead time and the DAQ busy veto.
- On acceptance it emits a fixed-width trigger pulse, a fixed-width MQDC gate and a latched hit pattern, and it keeps accepted/vetoed counters for slow-control readout.

Parameters:
- NCH, 48, width of hit pattern.
- TRIG_WIDTH, 6, trig_out high time in clk cycles (30 ns at 200 MHz); 1 ≤ TRIG_WIDTH ≤ GATE_WIDTH.
- GATE_WIDTH, 20, gate_out high time in clk cycles (100 ns).
- DEAD_TIME, 40, cycles of forced dead time after the gate ends; 0 skips DEAD.
- PS_W, 8, prescale register width.
- CNT_W, 32, counter width.

Ports:
- clk  input  1  200 MHz trigger clock (CLK_PCLK_RIGHT domain).
- reset  input  1  synchronous, active-high reset.
- fire_in  input  1  stretched OR level from the trigger stage.
- hit_pattern  input  NCH  stretched per-bar hits, valid while fire_in is high.
- prescale  input  PS_W  accept 1 of every (prescale+1) eligible edges; sampled every cycle.
- daq_busy  input  1  DAQ not ready; vetoes new acceptance.
- clear_counters  input  1  synchronous clear of both counters.
- trig_out  output  1  accepted-trigger pulse.
- gate_out  output  1  MQDC gate.
- pattern_out  output  NCH  hit pattern latched at accept.
- pattern_valid  output  1  one-cycle strobe when pattern_out updates.
- live  output  1  high only in IDLE with daq_busy low.
- accepted_count  output  CNT_W  accepted triggers, saturating.
- vetoed_count  output  CNT_W  edges rejected by busy, gate or dead time, saturating.

Behaviour:
- Reset values: all outputs 0, state IDLE, prescale counter 0, fire_d 0.
- Edge detect: fire_d is registered fire_in. An edge at cycle n means fire_in=1 and fire_d=0 at n. Only edges matter; a held level never retriggers.
- States: IDLE, GATE, DEAD, BUSYWAIT.
- IDLE, edge with daq_busy=1:
  - vetoed_count increments.
  - Prescale counter is unchanged.
- IDLE, edge with daq_busy=0, prescale counter ≠ prescale:
  - Prescale counter increments.
  - No other action; this is not a veto.
- IDLE, edge with daq_busy=0, prescale counter == prescale (accept):
  - Prescale counter is cleared.
  - pattern_out takes hit_pattern sampled at cycle n.
  - State goes to GATE.
- Accept outputs, timing from edge cycle n:
  - trig_out is high for cycles n+1 … n+TRIG_WIDTH.
  - gate_out is high for cycles n+1 … n+GATE_WIDTH.
  - pattern_valid is high at n+1 only.
  - accepted_count increments at n+1.
- GATE: lasts exactly GATE_WIDTH cycles, then goes to DEAD, or to the post-DEAD decision directly if DEAD_TIME=0.
- DEAD: lasts exactly DEAD_TIME cycles. On exit, daq_busy=1 goes to BUSYWAIT, otherwise IDLE.
- BUSYWAIT: returns to IDLE on the first cycle daq_busy is sampled 0. An edge on that same cycle is handled by IDLE rules one cycle later only if fire_in is still rising; it is not queued.
- Edges seen in GATE, DEAD or BUSYWAIT: vetoed_count increments, one per edge.
- Earliest re-accept: edge cycle n+GATE_WIDTH+DEAD_TIME+1.
- Prescale change: if the prescale counter is above a new, smaller prescale, the counter is cleared on the next eligible edge and that edge is accepted (test is counter ≥ prescale).
- Counters:
  - Saturate at 2^CNT_W−1; no wrap.
  - clear_counters zeroes both on the next edge of clk.
  - clear_counters and an increment in the same cycle give 0.
  - clear_counters does not affect the state machine or the prescale counter.
- reset mid-GATE: trig_out and gate_out drop on the next cycle and state returns to IDLE. A fire_in still high after reset is not an edge, because fire_d resets to 0 but is then loaded with 1 before the state returns to IDLE; the first post-reset cycle is masked.
- live: registered, equal to (state==IDLE && !daq_busy); 0 during reset.

Test Plan:
- prescale=0, daq_busy=0, single 6-cycle fire_in pulse at cycle 10 with hit_pattern=48'h1 → all of:
  - trig_out high for cycles 11–16.
  - gate_out high for cycles 11–30.
  - pattern_valid at 11 with pattern_out=48'h1.
  - accepted_count=1, vetoed_count=0.
- Two fire edges 25 cycles apart, default params → second edge vetoed: accepted=1, vetoed=1. Edges 61 cycles apart → both accepted.
- prescale=3, 12 well-separated edges → triggers on edges 4, 8 and 12 only: accepted=3, vetoed=0.
- daq_busy held high from cycle 30 to 200, edges at 10 and 100 → first accepted; second vetoed. live=0 from cycle 31 until 201 (BUSYWAIT exit). Edge at 210 is accepted.
- Preload counters near saturation (force edges with CNT_W=4 build) → accepted_count stops at 15. clear_counters coincident with an accept leaves accepted_count=0.
- reset asserted at cycle 15 of a gate while fire_in stays high → gate_out and trig_out are 0 at cycle 16. No new accept until fire_in falls and rises again.
